// File: rtl/network_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : network_mac_pkg
// Description : Shared widths and arithmetic helpers for the multi-lane
//               multiply-accumulate pipe (accumulator sizing, rounding
//               constant, signed saturation).
// Revision    : 1.0 - initial release
// ============================================================================
package network_mac_pkg;

    // Working width for the rounding/saturation path. It must exceed the
    // widest accumulator plus one carry bit for any supported configuration.
    localparam int c_MAXW = 128;

    typedef logic signed [c_MAXW-1:0] wide_t;

    // Accumulator width: full product width (a signed, b extended by one bit)
    // plus guard bits for long dot products.
    function automatic int acc_w(input int a_w, input int b_w, input int guard);
        return a_w + b_w + 1 + guard;
    endfunction

    // Half-LSB of the post-shift result; adding it before an arithmetic right
    // shift rounds half toward +inf. No rounding when nothing is shifted out.
    function automatic wide_t round_const(input int shift);
        wide_t v;
        v = '0;
        if (shift > 0) begin
            v = wide_t'(1) <<< (shift - 1);
        end
        return v;
    endfunction

    // Clamp a signed value into out_w signed bits.
    // Returns {sat_flag, value_or_limit}; the caller keeps the low out_w bits.
    function automatic logic [c_MAXW:0] sat_signed(input wide_t value, input int out_w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
        lo = ~hi;
        if (value > hi) begin
            return {1'b1, hi};
        end else if (value < lo) begin
            return {1'b1, lo};
        end
        return {1'b0, value};
    endfunction

endpackage
`default_nettype wire

// File: rtl/network_mac_lane.sv
`default_nettype none
// ============================================================================
// Module      : network_mac_lane
// Description : One MAC lane: input register, (optionally pipelined) signed
//               multiply, wrapping accumulator, round and saturate output
//               register. Control (valid/last/first) comes from the top.
// Ports       : clk, rst         clock, async active-high reset
//               i_en             pipe advance enable (hold on 0)
//               i_a, i_b         activation (signed), weight
//               i_acc_vld        a valid product reaches the accumulator
//               i_acc_first      that product starts a new sum
//               i_acc_done       accumulator holds a finished sum
//               o_data, o_sat    rounded/saturated result and clamp flag
// Revision    : 1.0 - initial release
// ============================================================================
module network_mac_lane
    import network_mac_pkg::*;
#(
    parameter int A_W       = 16,
    parameter int B_W       = 11,
    parameter int B_SIGNED  = 0,
    parameter int ACC_GUARD = 8,
    parameter int SHIFT     = 10,
    parameter int OUT_W     = 16,
    parameter int STAGES    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [A_W-1:0]   i_a,
    input  logic [B_W-1:0]   i_b,
    input  logic             i_acc_vld,
    input  logic             i_acc_first,
    input  logic             i_acc_done,
    output logic [OUT_W-1:0] o_data,
    output logic             o_sat
);

    localparam int    c_PW    = A_W + B_W + 1;
    localparam int    c_ACC_W = acc_w(A_W, B_W, ACC_GUARD);
    localparam wide_t c_RND   = round_const(SHIFT);

    typedef logic signed [c_PW-1:0]    prod_t;
    typedef logic signed [c_ACC_W-1:0] acc_t;

    logic signed [A_W-1:0] r_a;
    logic [B_W-1:0]        r_b;
    logic signed [B_W:0]   w_b_ext;
    prod_t                 w_prod;
    prod_t                 w_p_acc;
    acc_t                  r_acc;
    acc_t                  w_p_ext;
    wide_t                 w_sum;
    wide_t                 w_shr;
    logic [c_MAXW:0]       w_sat;
    logic                  w_unused;

    // Stage 1: operand capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_en) begin
            r_a <= i_a;
            r_b <= i_b;
        end
    end

    // One extra bit on b lets an unsigned weight ride through a signed multiply.
    assign w_b_ext = (B_SIGNED != 0) ? {r_b[B_W-1], r_b} : {1'b0, r_b};
    assign w_prod  = prod_t'(r_a) * prod_t'(w_b_ext);

    // Stages beyond three are spent as product registers ahead of the accumulator.
    generate
        if (STAGES > 3) begin : g_mul_pipe
            prod_t r_p [STAGES-3];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < STAGES - 3; i++) begin
                        r_p[i] <= '0;
                    end
                end else if (i_en) begin
                    r_p[0] <= w_prod;
                    for (int i = 1; i < STAGES - 3; i++) begin
                        r_p[i] <= r_p[i-1];
                    end
                end
            end
            assign w_p_acc = r_p[STAGES-4];
        end else begin : g_mul_comb
            assign w_p_acc = w_prod;
        end
    endgenerate

    assign w_p_ext = acc_t'(w_p_acc);

    // Accumulator wraps modulo 2^c_ACC_W; bubbles leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en && i_acc_vld) begin
            r_acc <= i_acc_first ? w_p_ext : r_acc + w_p_ext;
        end
    end

    // Round in a wider domain so the rounding add cannot overflow.
    assign w_sum    = wide_t'(r_acc) + c_RND;
    assign w_shr    = w_sum >>> SHIFT;
    assign w_sat    = sat_signed(w_shr, OUT_W);
    assign w_unused = ^w_sat[c_MAXW-1:OUT_W];

    // Output register: loads a finished sum, otherwise clears when advancing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data <= '0;
            o_sat  <= 1'b0;
        end else if (i_en) begin
            o_data <= i_acc_done ? w_sat[OUT_W-1:0] : '0;
            o_sat  <= i_acc_done & w_sat[c_MAXW];
        end
    end

endmodule
`default_nettype wire

// File: rtl/network_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : network_mac_pipe
// Description : LANES-wide pipelined multiply-accumulate with valid/ready
//               flow control. Holds the shared valid/last shift register,
//               the start-of-sum flag and the output handshake; per-lane
//               arithmetic lives in network_mac_lane.
// Ports       : clk, reset               clock, async active-high reset
//               in_valid/in_ready/in_last input beat handshake, end of sum
//               in_a, in_b                packed per-lane operands
//               out_valid/out_ready       result handshake
//               out_data, out_sat         packed results, per-lane clamp flags
// Revision    : 1.0 - initial release
// ============================================================================
module network_mac_pipe
    import network_mac_pkg::*;
#(
    parameter int LANES     = 1,
    parameter int A_W       = 16,
    parameter int B_W       = 11,
    parameter int B_SIGNED  = 0,
    parameter int ACC_GUARD = 8,
    parameter int SHIFT     = 10,
    parameter int OUT_W     = 16,
    parameter int STAGES    = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [LANES*A_W-1:0]   in_a,
    input  logic [LANES*B_W-1:0]   in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [LANES-1:0]       out_sat
);

    // Valid/last travel alongside the operand and product registers that sit
    // in front of the accumulator: stage 1 plus STAGES-3 product stages.
    localparam int c_PRE = STAGES - 2;

    logic w_en;
    logic r_vld  [c_PRE];
    logic r_last [c_PRE];
    logic w_acc_vld;
    logic w_acc_last;
    logic r_acc_first;
    logic r_acc_done;
    logic r_out_valid;

    // Whole-pipe stall: nothing moves while a result waits for downstream.
    assign w_en      = ~r_out_valid | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_PRE; i++) begin
                r_vld[i]  <= 1'b0;
                r_last[i] <= 1'b0;
            end
        end else if (w_en) begin
            r_vld[0]  <= in_valid;
            r_last[0] <= in_last;
            for (int i = 1; i < c_PRE; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_last[i] <= r_last[i-1];
            end
        end
    end

    assign w_acc_vld  = r_vld[c_PRE-1];
    assign w_acc_last = r_last[c_PRE-1];

    // r_acc_first marks that the next valid product opens a new sum;
    // r_acc_done marks that the accumulator now holds a closed sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc_first <= 1'b1;
            r_acc_done  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_en) begin
            if (w_acc_vld) begin
                r_acc_first <= w_acc_last;
            end
            r_acc_done  <= w_acc_vld & w_acc_last;
            r_out_valid <= r_acc_done;
        end
    end

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            network_mac_lane #(
                .A_W       (A_W),
                .B_W       (B_W),
                .B_SIGNED  (B_SIGNED),
                .ACC_GUARD (ACC_GUARD),
                .SHIFT     (SHIFT),
                .OUT_W     (OUT_W),
                .STAGES    (STAGES)
            ) u_lane (
                .clk         (clk),
                .rst         (reset),
                .i_en        (w_en),
                .i_a         (in_a[g*A_W +: A_W]),
                .i_b         (in_b[g*B_W +: B_W]),
                .i_acc_vld   (w_acc_vld),
                .i_acc_first (r_acc_first),
                .i_acc_done  (r_acc_done),
                .o_data      (out_data[g*OUT_W +: OUT_W]),
                .o_sat       (out_sat[g])
            );
        end
    endgenerate

endmodule
`default_nettype wire
